// File: rtl/funrv32_pkg.sv
// funrv32_pkg: shared widths and the register-file state encoding.
package funrv32_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   typedef enum logic {INIT, RUN} rf_state_e;
endpackage

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with x0 hardwired to zero,
// write-first forwarding and a hardware clear sequence after every reset.
module regfile_mp #(
   parameter int XLEN  = funrv32_pkg::XLEN,
   parameter int NREG  = 32,
   parameter int NREAD = 2,
   localparam int AW   = $clog2(NREG)
) (
   input  logic                  clk,
   input  logic                  resetb,
   output logic                  ready,
   input  logic                  we,
   input  logic [AW-1:0]         ad,
   input  logic [XLEN-1:0]       rd,
   input  logic                  re,
   input  logic [NREAD*AW-1:0]   a,
   output logic [NREAD*XLEN-1:0] r
);
   import funrv32_pkg::*;

   rf_state_e              state_q, state_d;
   logic [AW-1:0]          cnt_q, cnt_d;
   logic [NREAD*XLEN-1:0]  r_q, r_d, nxt;
   logic [XLEN-1:0]        mem_q [NREG];
   logic                   wen;
   logic [AW-1:0]          wad;
   logic [XLEN-1:0]        wdat;

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0] ai;
      assign ai = a[i*AW +: AW];
      assign nxt[i*XLEN +: XLEN] = (ai == '0) ? '0 : (we && ad == ai) ? rd : mem_q[ai];
   end

   // The clear sequence and the normal write share the single storage write port.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      wen     = 1'b0;
      wad     = ad;
      wdat    = rd;
      if (state_q == INIT) begin
         wen     = 1'b1;
         wad     = cnt_q;
         wdat    = '0;
         cnt_d   = cnt_q + AW'(1);
         r_d     = '0;
         state_d = (cnt_q == AW'(NREG - 1)) ? RUN : INIT;
      end else begin
         wen = we && (ad != '0);
         r_d = re ? nxt : r_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetb) begin
         state_q <= INIT;
         cnt_q   <= '0;
         r_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         if (wen) mem_q[wad] <= wdat;
      end
   end

   assign ready = (state_q == RUN);
   assign r     = r_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: vector table plus scoreboard queue for regfile_mp, with
// hand sequences for clear timing, stall and mid-run reset.
module tb_regfile_mp;
   logic        clk = 1'b0;
   logic        resetb, we, re, ready, ready16;
   logic [4:0]  ad;
   logic [31:0] rd, r16;
   logic [9:0]  a;
   logic [63:0] r;
   int          total = 0, bad = 0, n16 = 0;

   always #5 clk = ~clk;

   regfile_mp dut (
      .clk(clk), .resetb(resetb), .ready(ready), .we(we), .ad(ad),
      .rd(rd), .re(re), .a(a), .r(r)
   );

   regfile_mp #(.NREG(16), .NREAD(1)) dut16 (
      .clk(clk), .resetb(resetb), .ready(ready16), .we(1'b0), .ad(4'd0),
      .rd(32'd0), .re(1'b0), .a(4'd0), .r(r16)
   );

   typedef struct {
      logic        we;
      logic [4:0]  ad;
      logic [31:0] rd;
      logic [4:0]  a0, a1;
      logic [31:0] e0, e1;
   } vec_t;

   typedef struct {
      string       nm;
      logic [63:0] e;
   } exp_t;

   exp_t sbq[$];
   vec_t tbl[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] e);
      total++;
      if (act !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, e);
      end
   endtask

   task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic rr, input logic [4:0] a0, input logic [4:0] a1);
      we = w; ad = wa; rd = wd; re = rr; a = {a1, a0};
   endtask

   task automatic push(input string nm, input logic [31:0] e0, input logic [31:0] e1);
      exp_t x;
      x.nm = nm;
      x.e  = {e1, e0};
      sbq.push_back(x);
   endtask

   task automatic step_pop();
      exp_t x;
      step();
      if (sbq.size() == 0) begin
         total++; bad++;
         $display("FAIL scoreboard_empty: got 0 entries want 1");
      end else begin
         x = sbq.pop_front();
         chk(x.nm, r, x.e);
      end
   endtask

   task automatic wait_ready(input string nm, input int expn, input logic track16);
      int n = 0;
      do begin
         step();
         n++;
         if (n == 5) chk({nm, "_init_r"}, r, 64'd0);
         if (track16 && ready16 && n16 == 0) n16 = n;
      end while (!ready && n < 100);
      chk(nm, 64'(n), 64'(expn));
   endtask

   task automatic clear_check(input string nm);
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(31 - i));
         push(nm, 32'd0, 32'd0);
         step_pop();
      end
   endtask

   initial begin
      tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd1,  32'h0,        32'h0};
      tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
      tbl[2] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  32'h12345678, 32'h12345678};
      tbl[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h0,        32'h12345678};
      tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
      tbl[5] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd5,  5'd7,  32'hCAFEF00D, 32'h12345678};
      tbl[6] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd5,  32'hA5A5A5A5, 32'hCAFEF00D};
      tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd1,  32'hA5A5A5A5, 32'h0};

      resetb = 1'b0;
      drive(1'b1, 5'd3, 32'h55555555, 1'b1, 5'd3, 5'd3);
      repeat (3) step();
      chk("reset_ready", 64'(ready), 64'd0);
      chk("reset_r", r, 64'd0);
      resetb = 1'b1;
      wait_ready("clear_cycles", 32, 1'b1);
      chk("clear_cycles_nreg16", 64'(n16), 64'd16);
      clear_check("clear_read");

      foreach (tbl[k]) begin
         drive(tbl[k].we, tbl[k].ad, tbl[k].rd, 1'b1, tbl[k].a0, tbl[k].a1);
         push($sformatf("vec%0d", k), tbl[k].e0, tbl[k].e1);
         step_pop();
      end

      drive(1'b1, 5'd8, 32'hA, 1'b1, 5'd8, 5'd8);
      push("stall_setup", 32'hA, 32'hA);
      step_pop();
      drive(1'b1, 5'd9, 32'hB, 1'b0, 5'd9, 5'd9);
      step();
      chk("stall_hold", r, {32'hA, 32'hA});
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd8);
      push("stall_release", 32'hB, 32'hA);
      step_pop();

      for (int i = 1; i < 32; i++) begin
         drive(1'b1, 5'(i), 32'(i) * 32'h01010101 + 32'd1, 1'b0, 5'd0, 5'd0);
         step();
      end
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd17, 5'd31);
      push("populate", 32'h11111112, 32'h1F1F1F20);
      step_pop();
      resetb = 1'b0;
      drive(1'b1, 5'd4, 32'h77777777, 1'b1, 5'd17, 5'd31);
      step();
      chk("midrun_ready", 64'(ready), 64'd0);
      chk("midrun_r", r, 64'd0);
      resetb = 1'b1;
      wait_ready("midrun_clear_cycles", 32, 1'b0);
      clear_check("midrun_read");

      if (sbq.size() != 0) begin
         total++; bad++;
         $display("FAIL scoreboard_leftover: got %0d entries want 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data width in bits.
REQ-002 The block SHALL have parameter NREG, default 32, meaning architectural register count; legal values are 16 (RV32E) and 32.
REQ-003 The block SHALL have parameter NREAD, default 2, meaning number of independent read ports (1..4).
REQ-004 The block SHALL have derived localparam AW = $clog2(NREG), meaning register address width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port resetb, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port ready, output, 1 bit: high once the post-reset clear has completed.
REQ-008 The block SHALL have port we, input, 1 bit: write enable.
REQ-009 The block SHALL have port ad, input, AW bits: write address.
REQ-010 The block SHALL have port rd, input, XLEN bits: write data.
REQ-011 The block SHALL have port re, input, 1 bit: read enable; when low, all read outputs hold (pipeline stall).
REQ-012 The block SHALL have port a, input, NREAD*AW bits: packed read addresses; port i uses a[i*AW +: AW].
REQ-013 The block SHALL have port r, output, NREAD*XLEN bits: packed registered read data; port i uses r[i*XLEN +: XLEN].

Function
REQ-014 The block SHALL implement states INIT and RUN.
REQ-015 In INIT, the block SHALL write zero to entry cnt each cycle and increment cnt; after entry NREG-1 is written, the next state SHALL be RUN (NREG cycles in INIT).
REQ-016 ready SHALL be 1 exactly while in RUN.
REQ-017 In INIT, we SHALL be ignored and r SHALL be driven to 0 regardless of re.
REQ-018 In RUN, when we=1 and ad!=0, the block SHALL store rd into entry ad at the clock edge.
REQ-019 Writes to address 0 SHALL be discarded; entry 0 SHALL always read as 0.
REQ-020 Read latency SHALL be 1 cycle: when re=1 in RUN, r_i SHALL be loaded with the value of register a_i as of the clock edge.
REQ-021 Port i SHALL load 0 when a_i=0.
REQ-022 Otherwise, port i SHALL load rd when we=1 and ad=a_i (write-first forwarding, same cycle).
REQ-023 Otherwise, port i SHALL load the stored value of entry a_i.
REQ-024 When re=0, r SHALL hold its value; a write in the same cycle SHALL still commit, and is visible on the next read with re=1.
REQ-025 Multiple ports addressing the same register SHALL all return identical data, including the forwarded case.
REQ-026 Addresses SHALL be used unmodified (no bit inversion); no address exceeds NREG-1 by construction.

Reset
REQ-027 On a clock edge with resetb=0, the block SHALL set state=INIT, cnt=0, ready=0 and r=0, and SHALL discard any write in that cycle.
REQ-028 Reset asserted mid-INIT or mid-RUN SHALL restart the full clear; no stored value SHALL survive a reset.
REQ-029 While resetb=0, the block SHALL hold INIT with cnt=0; clearing SHALL begin on the first edge with resetb=1.

Structure
REQ-030 A shared package funrv32_pkg SHALL hold XLEN, the register-address width for 32 registers, and the regfile state enum (INIT, RUN).
REQ-031 The block SHALL have no sub-module; storage SHALL be inferred as a single array written by one port (the clear and the normal write mux onto it).
REQ-032 Read ports SHALL be generated by a generate loop over NREAD.

Verification
REQ-033 Clear after reset: hold resetb=0 for 3 cycles, release -> ready=0 for exactly 32 cycles, then 1; every address read returns 0.
REQ-034 Write/read: write x5=0xDEADBEEF; the next cycle read a0=5 with re=1 -> r0=0xDEADBEEF after 1 cycle.
REQ-035 Forwarding: same cycle we=1, ad=7, rd=0x12345678, a0=a1=7, re=1 -> r0=r1=0x12345678 at the next edge.
REQ-036 x0: write ad=0, rd=0xFFFFFFFF, read a0=0 concurrently and afterwards -> r0=0 both times.
REQ-037 Stall: r0 showing 0xA; set re=0, a0=9, write x9=0xB -> r0 stays 0xA; raise re -> r0=0xB.
REQ-038 Mid-run reset: populate x1..x31, pulse resetb=0 for 1 cycle -> ready falls; after 32 cycles all reads return 0; NREG=16 build -> ready after 16 cycles.
